// File: rtl/alu_system_ctrl.sv
// Hardwired three-cycle sequencer for the ALU system: two byte-fetch cycles
// followed by one execute cycle, with an absorbing HALT state.
module alu_system_ctrl (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IROut,
  input  logic [3:0]  ALUOutFlag,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Enable,
  output logic [1:0]  IR_Funsel,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [1:0]  State,
  output logic        Halted,
  output logic        Illegal
);

  localparam logic [1:0] FETCH_L = 2'd0;
  localparam logic [1:0] FETCH_H = 2'd1;
  localparam logic [1:0] EXEC    = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam logic [3:0] OP_LDI   = 4'd0;
  localparam logic [3:0] OP_LDM   = 4'd1;
  localparam logic [3:0] OP_STM   = 4'd2;
  localparam logic [3:0] OP_ALU   = 4'd3;
  localparam logic [3:0] OP_BRZ   = 4'd4;
  localparam logic [3:0] OP_INCAR = 4'd5;
  localparam logic [3:0] OP_HLT   = 4'd15;

  localparam logic [1:0] FUN_CLR  = 2'b00;
  localparam logic [1:0] FUN_LOAD = 2'b01;
  localparam logic [1:0] FUN_INC  = 2'b10;

  localparam logic [1:0] ARF_PC = 2'd0;
  localparam logic [1:0] ARF_AR = 2'd1;

  localparam logic [3:0] REG_PC = 4'b1000;
  localparam logic [3:0] REG_AR = 4'b0100;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic [3:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;
  logic [3:0] rd_onehot;
  logic       zero_flag;

  assign op        = IROut[15:12];
  assign rd        = IROut[11:10];
  assign rs1       = IROut[9:8];
  assign rs2       = IROut[7:6];
  assign zero_flag = ALUOutFlag[3];

  // RD = 0 addresses R1, which sits in the most significant enable bit.
  always_comb begin
    case (rd)
      2'd0:    rd_onehot = 4'b1000;
      2'd1:    rd_onehot = 4'b0100;
      2'd2:    rd_onehot = 4'b0010;
      default: rd_onehot = 4'b0001;
    endcase
  end

  always_comb begin
    case (state_q)
      FETCH_L: state_d = FETCH_H;
      FETCH_H: state_d = EXEC;
      EXEC:    state_d = (op == OP_HLT) ? HALT : FETCH_L;
      default: state_d = HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge value regardless of block evaluation order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= FETCH_L;
    end else begin
      state_q <= state_d;
    end
  end

  assign State = state_q;

  // NOTE: every output receives its idle value before the case statement, so
  // no path through this block leaves a signal unassigned and infers a latch.
  always_comb begin
    RF_OutASel  = 3'd0;
    RF_OutBSel  = 3'd0;
    RF_FunSel   = FUN_CLR;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutCSel = 2'd0;
    ARF_OutDSel = 2'd0;
    ARF_FunSel  = FUN_CLR;
    ARF_RegSel  = 4'b0000;
    IR_LH       = 1'b0;
    IR_Enable   = 1'b0;
    IR_Funsel   = FUN_CLR;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    MuxASel     = 2'd0;
    MuxBSel     = 2'd0;
    MuxCSel     = 1'b0;
    Halted      = 1'b0;
    Illegal     = 1'b0;

    // Reset gates the decode so outputs go idle without waiting for a clock.
    if (Reset) begin
      case (state_q)
        FETCH_L, FETCH_H: begin
          Mem_CS      = 1'b0;
          ARF_OutDSel = ARF_PC;
          IR_Enable   = 1'b1;
          IR_Funsel   = FUN_LOAD;
          IR_LH       = (state_q == FETCH_H);
          ARF_RegSel  = REG_PC;
          ARF_FunSel  = FUN_INC;
        end

        EXEC: begin
          case (op)
            OP_LDI: begin
              RF_RSel   = rd_onehot;
              MuxASel   = 2'd2;
              RF_FunSel = FUN_LOAD;
            end
            OP_LDM: begin
              ARF_OutDSel = ARF_AR;
              Mem_CS      = 1'b0;
              RF_RSel     = rd_onehot;
              MuxASel     = 2'd1;
              RF_FunSel   = FUN_LOAD;
            end
            OP_STM: begin
              RF_OutASel  = {1'b0, rs1};
              MuxCSel     = 1'b0;
              ALU_FunSel  = 4'b0000;
              ARF_OutDSel = ARF_AR;
              Mem_CS      = 1'b0;
              Mem_WR      = 1'b1;
            end
            OP_ALU: begin
              RF_OutASel = {1'b0, rs1};
              RF_OutBSel = {1'b0, rs2};
              ALU_FunSel = IROut[5:2];
              RF_RSel    = rd_onehot;
              MuxASel    = 2'd0;
              RF_FunSel  = FUN_LOAD;
            end
            OP_BRZ: begin
              if (zero_flag) begin
                MuxBSel    = 2'd2;
                ARF_RegSel = REG_PC;
                ARF_FunSel = FUN_LOAD;
              end
            end
            OP_INCAR: begin
              ARF_RegSel = REG_AR;
              ARF_FunSel = FUN_INC;
            end
            OP_HLT: begin
            end
            default: begin
              Illegal = 1'b1;
            end
          endcase
        end

        default: begin
          Halted = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_system_ctrl.sv
// Self-checking bench for alu_system_ctrl: compares every control output each
// cycle against a behavioural model and emulates the PC register.
module tb_alu_system_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IROut;
  logic [3:0]  ALUOutFlag;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [3:0]  ARF_RegSel;
  logic        IR_LH, IR_Enable;
  logic [1:0]  IR_Funsel;
  logic        Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [1:0]  State;
  logic        Halted, Illegal;

  alu_system_ctrl dut (
    .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
    .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .State(State), .Halted(Halted), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] rf_a;
    logic [2:0] rf_b;
    logic [1:0] rf_fun;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_fun;
    logic [1:0] arf_c;
    logic [1:0] arf_d;
    logic [1:0] arf_fun;
    logic [3:0] arf_reg;
    logic       ir_lh;
    logic       ir_en;
    logic [1:0] ir_fun;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic [1:0] state;
    logic       halted;
    logic       illegal;
  } ctrl_t;

  int passed = 0;
  int total  = 0;
  int phase;            // model sequencer position: 0,1 fetch, 2 exec, 3 halted
  logic [15:0] pc;      // PC register emulated from the DUT's control outputs

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.rf_a = RF_OutASel;    c.rf_b = RF_OutBSel;   c.rf_fun = RF_FunSel;
    c.rf_rsel = RF_RSel;    c.rf_tsel = RF_TSel;   c.alu_fun = ALU_FunSel;
    c.arf_c = ARF_OutCSel;  c.arf_d = ARF_OutDSel; c.arf_fun = ARF_FunSel;
    c.arf_reg = ARF_RegSel; c.ir_lh = IR_LH;       c.ir_en = IR_Enable;
    c.ir_fun = IR_Funsel;   c.mem_wr = Mem_WR;     c.mem_cs = Mem_CS;
    c.mux_a = MuxASel;      c.mux_b = MuxBSel;     c.mux_c = MuxCSel;
    c.state = State;        c.halted = Halted;     c.illegal = Illegal;
    return c;
  endfunction

  // Expected controls derived directly from the instruction semantics.
  function automatic ctrl_t model(int ph, logic [15:0] ir, logic [3:0] fl, logic rst);
    ctrl_t c = '0;
    int op = int'(ir[15:12]);
    int rd = int'(ir[11:10]);
    c.mem_cs = 1'b1;
    if (!rst) return c;
    c.state = 2'(ph);
    if (ph < 2) begin
      c.mem_cs = 1'b0; c.ir_en = 1'b1; c.ir_fun = 2'b01; c.ir_lh = (ph == 1);
      c.arf_reg = 4'b1000; c.arf_fun = 2'b10;
    end else if (ph == 3) begin
      c.halted = 1'b1;
    end else begin
      if (op == 0 || op == 1 || op == 3) begin
        c.rf_rsel = 4'(8 >> rd);
        c.rf_fun  = 2'b01;
      end
      if (op == 0) c.mux_a = 2'd2;
      if (op == 1) begin
        c.arf_d = 2'd1; c.mem_cs = 1'b0; c.mux_a = 2'd1;
      end
      if (op == 2) begin
        c.rf_a = {1'b0, ir[9:8]}; c.arf_d = 2'd1; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
      end
      if (op == 3) begin
        c.rf_a = {1'b0, ir[9:8]}; c.rf_b = {1'b0, ir[7:6]}; c.alu_fun = ir[5:2];
      end
      if (op == 4 && fl[3]) begin
        c.mux_b = 2'd2; c.arf_reg = 4'b1000; c.arf_fun = 2'b01;
      end
      if (op == 5) begin
        c.arf_reg = 4'b0100; c.arf_fun = 2'b10;
      end
      if (op > 5 && op < 15) c.illegal = 1'b1;
    end
    return c;
  endfunction

  // Sample one cycle, apply the DUT's PC controls to the emulated PC, advance.
  task automatic step(output ctrl_t obs, output ctrl_t exp);
    #1;
    obs = dut_ctrl();
    exp = model(phase, IROut, ALUOutFlag, Reset);
    if (Reset && obs.arf_reg[3]) begin
      case (obs.arf_fun)
        2'b00: pc = 16'h0;
        2'b01: pc = (obs.mux_b == 2'd2) ? {8'h00, IROut[7:0]} : 16'hxxxx;
        2'b10: pc = pc + 16'd1;
        default: pc = pc - 16'd1;
      endcase
    end
    @(posedge Clock);
    if (!Reset) phase = 0;
    else if (phase == 2) phase = (IROut[15:12] == 4'hF) ? 3 : 0;
    else if (phase < 2) phase = phase + 1;
    #1;
  endtask

  task automatic exec_instr(input logic [15:0] ir, input logic [3:0] fl,
                            output ctrl_t o[3], output ctrl_t e[3],
                            output logic [15:0] pc_start);
    IROut = ir;
    ALUOutFlag = fl;
    pc_start = pc;
    for (int i = 0; i < 3; i++) step(o[i], e[i]);
  endtask

  task automatic test_reset();
    ctrl_t o, e;
    Reset = 1'b0; IROut = 16'h0000; ALUOutFlag = 4'h0; phase = 0; pc = 16'h0;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    o = dut_ctrl();
    e = model(0, IROut, ALUOutFlag, 1'b0);
    total++;
    if (o !== e) $display("FAIL reset_idle: got %h want %h", o, e);
    else passed++;
    total++;
    if (State !== 2'd0 || Mem_CS !== 1'b1 || IR_Enable !== 1'b0)
      $display("FAIL reset_state: State=%0d Mem_CS=%b IR_Enable=%b want 0/1/0",
               State, Mem_CS, IR_Enable);
    else passed++;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(o, e);
      total++;
      if (o !== e) $display("FAIL reset_first_instr cyc%0d: got %h want %h", i, o, e);
      else passed++;
      if (i == 0) begin
        total++;
        if (o.ir_lh !== 1'b0 || o.arf_fun !== 2'b10)
          $display("FAIL reset_first_fetch: IR_LH=%b ARF_FunSel=%b want 0/10",
                   o.ir_lh, o.arf_fun);
        else passed++;
      end
    end
  endtask

  task automatic test_ldi();
    ctrl_t o[3], e[3];
    logic [15:0] p0;
    exec_instr(16'h0A5C, 4'h0, o, e, p0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o[i] !== e[i]) $display("FAIL ldi cyc%0d: got %h want %h", i, o[i], e[i]);
      else passed++;
    end
    total++;
    if (o[2].rf_rsel !== 4'b0010 || o[2].mux_a !== 2'd2 || o[2].rf_fun !== 2'b01)
      $display("FAIL ldi_fields: RSel=%b MuxA=%0d Fun=%b want 0010/2/01",
               o[2].rf_rsel, o[2].mux_a, o[2].rf_fun);
    else passed++;
    total++;
    if ({o[0].state, o[1].state, o[2].state, State} !== 8'b00_01_10_00)
      $display("FAIL ldi_states: got %0d %0d %0d %0d want 0 1 2 0",
               o[0].state, o[1].state, o[2].state, State);
    else passed++;
    total++;
    if (pc !== p0 + 16'd2) $display("FAIL ldi_pc: got %h want %h", pc, p0 + 16'd2);
    else passed++;
  endtask

  task automatic test_alu_stm();
    ctrl_t o[3], e[3];
    logic [15:0] p0;
    exec_instr(16'h3610, 4'h0, o, e, p0);
    total++;
    if (o[2] !== e[2] || o[2].rf_a !== 3'd2 || o[2].rf_b !== 3'd0 ||
        o[2].alu_fun !== 4'b0100 || o[2].rf_rsel !== 4'b0100)
      $display("FAIL alu_exec: got %h want %h", o[2], e[2]);
    else passed++;
    exec_instr(16'h2200, 4'h0, o, e, p0);
    total++;
    if (o[2] !== e[2] || o[2].mem_wr !== 1'b1 || o[2].mem_cs !== 1'b0 ||
        o[2].arf_d !== 2'd1 || o[2].rf_a !== 3'd2)
      $display("FAIL stm_exec: got %h want %h", o[2], e[2]);
    else passed++;
    exec_instr(16'h1400, 4'h0, o, e, p0);
    total++;
    if (o[2] !== e[2]) $display("FAIL ldm_exec: got %h want %h", o[2], e[2]);
    else passed++;
    exec_instr(16'h5000, 4'h0, o, e, p0);
    total++;
    if (o[2] !== e[2]) $display("FAIL incar_exec: got %h want %h", o[2], e[2]);
    else passed++;
  endtask

  task automatic test_brz();
    ctrl_t o[3], e[3];
    logic [15:0] p0;
    exec_instr(16'h4040, 4'b1000, o, e, p0);
    total++;
    if (o[2] !== e[2] || o[2].arf_reg !== 4'b1000 || o[2].mux_b !== 2'd2)
      $display("FAIL brz_taken: got %h want %h", o[2], e[2]);
    else passed++;
    total++;
    if (pc !== 16'h0040) $display("FAIL brz_taken_pc: got %h want 0040", pc);
    else passed++;
    exec_instr(16'h4040, 4'b0111, o, e, p0);
    total++;
    if (o[2] !== e[2] || o[2].arf_reg !== 4'b0000)
      $display("FAIL brz_not_taken: got %h want %h", o[2], e[2]);
    else passed++;
    total++;
    if (pc !== 16'h0042) $display("FAIL brz_not_taken_pc: got %h want 0042", pc);
    else passed++;
  endtask

  task automatic test_random();
    ctrl_t o[3], e[3];
    logic [15:0] p0, ir, want_pc;
    logic [3:0] fl;
    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom);
      ir[15:12] = 4'($urandom_range(0, 14));
      fl = 4'($urandom);
      exec_instr(ir, fl, o, e, p0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if (o[i] !== e[i])
          $display("FAIL random ir=%h cyc%0d: got %h want %h", ir, i, o[i], e[i]);
        else passed++;
      end
      want_pc = (ir[15:12] == 4'd4 && fl[3]) ? {8'h00, ir[7:0]} : p0 + 16'd2;
      total++;
      if (pc !== want_pc) $display("FAIL random_pc ir=%h: got %h want %h", ir, pc, want_pc);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    ctrl_t o[3], e[3];
    logic [15:0] p0;
    exec_instr(16'h7000, 4'h0, o, e, p0);
    total++;
    if (o[2] !== e[2] || o[2].illegal !== 1'b1 || o[1].illegal !== 1'b0)
      $display("FAIL illegal_pulse: got %h want %h", o[2], e[2]);
    else passed++;
    total++;
    if (State !== 2'd0 || Illegal !== 1'b0)
      $display("FAIL illegal_return: State=%0d Illegal=%b want 0/0", State, Illegal);
    else passed++;
  endtask

  task automatic test_reset_mid();
    ctrl_t o, e;
    IROut = 16'h0123;
    step(o, e);
    total++;
    if (o !== e || State !== 2'd1) $display("FAIL mid_fetch_h: State=%0d want 1", State);
    else passed++;
    Reset = 1'b0;
    #1;
    total++;
    if (State !== 2'd0 || Mem_CS !== 1'b1 || IR_Enable !== 1'b0 || ARF_RegSel !== 4'b0)
      $display("FAIL mid_reset_async: State=%0d Mem_CS=%b IR_Enable=%b RegSel=%b want 0/1/0/0",
               State, Mem_CS, IR_Enable, ARF_RegSel);
    else passed++;
    @(posedge Clock); #1;
    Reset = 1'b1;
    phase = 0;
    step(o, e);
    total++;
    if (o !== e) $display("FAIL mid_reset_release: got %h want %h", o, e);
    else passed++;
    step(o, e);
    step(o, e);
  endtask

  task automatic test_halt();
    ctrl_t o[3], e[3], oh, eh;
    logic [15:0] p0;
    exec_instr(16'hF000, 4'h0, o, e, p0);
    total++;
    if (o[2] !== e[2]) $display("FAIL hlt_exec: got %h want %h", o[2], e[2]);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      IROut = 16'($urandom);
      step(oh, eh);
      total++;
      if (oh !== eh || oh.halted !== 1'b1 || oh.state !== 2'd3)
        $display("FAIL halt_hold cyc%0d: got %h want %h", i, oh, eh);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu_stm();
    test_brz();
    test_random();
    test_illegal();
    test_reset_mid();
    test_halt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_system_ctrl.md
# alu_system_ctrl

Hardwired sequencer driving every control input of the ALU system (register file, address register file, instruction register, memory, muxes, ALU). It fetches a 16-bit instruction from memory at PC in two byte cycles, then executes it in one cycle, so every instruction takes 3 clocks. It sits beside the ALU system: control outputs feed its ports 1:1, and it observes `IROut` and `ALUOutFlag` back.

## Interface
- No parameters; all widths fixed by the ALU system ports.
- `Clock` in 1: system clock, all state updates on rising edge.
- `Reset` in 1: asynchronous, active-low; 0 forces FETCH_L and idle outputs immediately.
- `IROut` in 16: instruction register contents.
- `ALUOutFlag` in 4: registered ALU flags {Z,C,N,O}, bit 3 = Z.
- `RF_OutASel`, `RF_OutBSel` out 3: 3'd0..3'd3 select R1..R4.
- `RF_FunSel` out 2, `RF_RSel` out 4, `RF_TSel` out 4.
- `ALU_FunSel` out 4.
- `ARF_OutCSel`, `ARF_OutDSel` out 2: 2'd0 = PC, 2'd1 = AR, 2'd2 = SP.
- `ARF_FunSel` out 2, `ARF_RegSel` out 4: bit 3 = PC, bit 2 = AR, bit 1 = SP.
- `IR_LH` out 1, `IR_Enable` out 1, `IR_Funsel` out 2.
- `Mem_WR` out 1: 1 = write. `Mem_CS` out 1: active-low chip select.
- `MuxASel` out 2: RF input; 0 = ALUOut, 1 = MemoryOut, 2 = IROut[7:0], 3 = ARF OutC.
- `MuxBSel` out 2: ARF input; 2 = IROut[7:0].
- `MuxCSel` out 1: 0 = RF AOut to ALU A.
- `State` out 2: 0 = FETCH_L, 1 = FETCH_H, 2 = EXEC, 3 = HALT.
- `Halted` out 1, `Illegal` out 1: pulse for one EXEC cycle on an undefined opcode.

## Operation
- Encodings shared by all FunSel ports: 00 clear, 01 load, 10 increment, 11 decrement.
- Register enables: a selected register is one-hot, bit = 1 enabled.
- Idle value of every output (reset, HALT, unused fields): all 0, except `Mem_CS` = 1.
- FETCH_L:
  - `Mem_CS` = 0, `Mem_WR` = 0, `ARF_OutDSel` = PC.
  - `IR_Enable` = 1, `IR_Funsel` = 01, `IR_LH` = 0.
  - `ARF_RegSel` = 4'b1000, `ARF_FunSel` = 10 (PC++).
  - Next state FETCH_H.
- FETCH_H: same as FETCH_L but `IR_LH` = 1. Next state EXEC.
- EXEC fields: op = IR[15:12], RD = IR[11:10], RS1 = IR[9:8], RS2 = IR[7:6], IMM = IR[7:0]. RD one-hot: RD = 0 → `RF_RSel` 4'b1000, RD = 3 → 4'b0001.
- op 0 LDI: RD ← IMM. `MuxASel` = 2, `RF_FunSel` = 01.
- op 1 LDM: RD ← M[AR]. `ARF_OutDSel` = AR, `Mem_CS` = 0, `MuxASel` = 1, `RF_FunSel` = 01.
- op 2 STM: M[AR] ← RS1.
  - `RF_OutASel` = RS1, `MuxCSel` = 0, `ALU_FunSel` = 4'b0000 (pass A).
  - `ARF_OutDSel` = AR, `Mem_CS` = 0, `Mem_WR` = 1.
- op 3 ALU: RD ← RS1 op RS2, with `ALU_FunSel` = IR[5:2].
  - `RF_OutASel` = RS1, `RF_OutBSel` = RS2.
  - `MuxASel` = 0, `RF_FunSel` = 01.
- op 4 BRZ: if `ALUOutFlag`[3] = 1, PC ← IMM (`MuxBSel` = 2, `ARF_RegSel` = 4'b1000, `ARF_FunSel` = 01). Otherwise idle outputs.
- op 5 INCAR: AR ← AR + 1.
- op 15 HLT: next state HALT.
- Other opcodes: idle outputs, `Illegal` = 1.
- After any EXEC other than HLT, next state is FETCH_L.
- HALT: absorbing, idle outputs, `Halted` = 1; left only by `Reset` = 0.
- The block contains no datapath registers; only the 2-bit state register is stored.

## Timing
- Outputs are combinational from the registered state and `IROut`; registers in the ALU system capture them at the rising edge that ends the state.
- Latency:
  - IR low byte valid after the FETCH_L edge, high byte after the FETCH_H edge.
  - EXEC results are visible 3 edges after entering FETCH_L.
  - PC advances by 2 per instruction.
- BRZ samples `ALUOutFlag` during EXEC; the taken PC load and the EXEC→FETCH_L transition occur on the same edge, so the next fetch uses the new PC.
- Reset asserted mid-instruction:
  - State goes to FETCH_L and outputs go idle asynchronously.
  - Partially fetched IR and PC are not restored by this block.
  - Release is sampled on the next rising edge.

## Test plan
- Reset low for 2 cycles, then released: `State` = 0, `Mem_CS` = 1, all enables 0; first edge after release shows `IR_LH` = 0 and `ARF_FunSel` = 10.
- IR = 16'h0A5C (LDI R3, 0x5C) in EXEC: `RF_RSel` = 4'b0010, `MuxASel` = 2, `RF_FunSel` = 01; `State` sequence 0, 1, 2, 0.
- IR = 16'h3610 with op bits IR[5:2] = 4'b0100: `RF_OutASel` = 3'd2, `RF_OutBSel` = 3'd0, `ALU_FunSel` = 4'b0100, `RF_RSel` = 4'b0100.
- IR = 16'h2200 (STM R3): `Mem_WR` = 1, `Mem_CS` = 0, `ARF_OutDSel` = 1, `RF_OutASel` = 3'd2.
- BRZ 0x40 with Z = 1 → PC load enabled with `MuxBSel` = 2; repeated with Z = 0 → `ARF_RegSel` = 0.
- IR = 16'hF000 → HALT with `Halted` = 1 held for 10 cycles; IR = 16'h7000 → `Illegal` pulses for 1 cycle, then FETCH_L; Reset pulse in FETCH_H → `State` = 0 immediately.
